// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
//   Shared definitions for the PE job controller slice:
//   - 3-bit FSM state encodings and the state_t enum built from them
//   - MODE_STREAM: the mode value that selects a streaming pass
//   - state_is_busy(): true while a job is in flight (not IDLE / DONE)
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_DISPATCH = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_PRIME    = 3'd4;
  localparam logic [2:0] ST_ROW      = 3'd5;
  localparam logic [2:0] ST_DRAIN    = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_LOAD     = ST_LOAD,
    S_DISPATCH = ST_DISPATCH,
    S_STREAM   = ST_STREAM,
    S_PRIME    = ST_PRIME,
    S_ROW      = ST_ROW,
    S_DRAIN    = ST_DRAIN,
    S_DONE     = ST_DONE
  } state_t;

  localparam int unsigned MODE_STREAM = 0;

  function automatic logic state_is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/pe_job_controller_if.sv
// -----------------------------------------------------------------------------
// pe_job_controller_if
//   Bundles the host job handshake, datapath status inputs and datapath
//   control outputs of the PE job controller.
//   Parameters: MODE_W (mode width), ROW_W (row_count / row_idx width).
//   Modports:
//     master : the controller (receives job request + status, drives controls)
//     slave  : the surrounding host / datapath environment
//   Host:     start, mode, row_count, just_add -> ; <- busy, done, row_idx
//   Status:   full_done, stride_pos_ld, psum_done, stride_count_flag,
//             psum_buf_empty, psum_empty
//   Controls: reset_all, if_read_start, filter_read_start, start_rd_gen,
//             clear_regs, reset_filter, usage_stride_pos_ld, psum_clear,
//             psum_ren, psum_same_addr, accumulate
// -----------------------------------------------------------------------------
interface pe_job_controller_if #(
  parameter int MODE_W = 2,
  parameter int ROW_W  = 3
);

  // host handshake
  logic              start;
  logic [MODE_W-1:0] mode;
  logic [ROW_W-1:0]  row_count;
  logic              just_add;
  logic              busy;
  logic              done;
  logic [ROW_W-1:0]  row_idx;

  // datapath status
  logic full_done;
  logic stride_pos_ld;
  logic psum_done;
  logic stride_count_flag;
  logic psum_buf_empty;
  logic psum_empty;

  // datapath controls
  logic reset_all;
  logic if_read_start;
  logic filter_read_start;
  logic start_rd_gen;
  logic clear_regs;
  logic reset_filter;
  logic usage_stride_pos_ld;
  logic psum_clear;
  logic psum_ren;
  logic psum_same_addr;
  logic accumulate;

  modport master (
    input  start, mode, row_count, just_add,
    input  full_done, stride_pos_ld, psum_done, stride_count_flag,
           psum_buf_empty, psum_empty,
    output busy, done, row_idx,
    output reset_all, if_read_start, filter_read_start, start_rd_gen,
           clear_regs, reset_filter, usage_stride_pos_ld, psum_clear,
           psum_ren, psum_same_addr, accumulate
  );

  modport slave (
    output start, mode, row_count, just_add,
    output full_done, stride_pos_ld, psum_done, stride_count_flag,
           psum_buf_empty, psum_empty,
    input  busy, done, row_idx,
    input  reset_all, if_read_start, filter_read_start, start_rd_gen,
           clear_regs, reset_filter, usage_stride_pos_ld, psum_clear,
           psum_ren, psum_same_addr, accumulate
  );

endinterface

// File: rtl/pe_row_tracker.sv
// -----------------------------------------------------------------------------
// pe_row_tracker
//   Row index counter for row-mode jobs.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clear      : force row_idx to 0 (job start), wins over inc
//     inc        : advance to the next row
//     rows       : latched row count; 0 is treated as a single row
//     row_idx    : current row, 0-based
//     last_row   : row_idx is the final row of the job
// -----------------------------------------------------------------------------
module pe_row_tracker #(
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [ROW_W-1:0] rows,
  output logic [ROW_W-1:0] row_idx,
  output logic             last_row
);

  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [ROW_W-1:0] last_idx;

  // rows==0 collapses to one row, so the last index is 0 in that case too.
  assign last_idx = (rows == '0) ? '0 : (rows - ROW_W'(1));
  // >= keeps the counter pinned even if rows shrinks under it.
  assign last_row = (row_idx_q >= last_idx);
  assign row_idx  = row_idx_q;

  always_comb begin
    row_idx_d = row_idx_q;
    if (clear) begin
      row_idx_d = '0;
    end else if (inc && !last_row) begin
      row_idx_d = row_idx_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx_q <= '0;
    end else begin
      row_idx_q <= row_idx_d;
    end
  end

endmodule

// File: rtl/pe_job_controller.sv
// -----------------------------------------------------------------------------
// pe_job_controller
//   Sequences one convolution job per start request: IF/filter read kick-off,
//   read-address generation, then either a streaming pass, a multi-row stride
//   pass, or a psum drain/accumulate pass, ending with a one-cycle done pulse.
//   A start in any state aborts the current job and restarts from LOAD.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     bus         : pe_job_controller_if.master (host handshake, datapath
//                   status and controls)
//     job_cycles  : [15:0] busy-cycle counter, only when PE_JOB_PERF_EN is
//                   defined (cleared on start, saturating)
//   Optional feature macro: PE_JOB_PERF_EN
// -----------------------------------------------------------------------------
module pe_job_controller
  import pe_ctrl_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int ROW_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_job_controller_if.master  bus
`ifdef PE_JOB_PERF_EN
  ,
  output logic [15:0]          job_cycles
`endif
);

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              just_add_q, just_add_d;

  logic              row_clear;
  logic              row_inc;
  logic              last_row;
  logic [ROW_W-1:0]  row_idx;
  logic              busy;

  logic reset_all, if_read_start, filter_read_start, start_rd_gen;
  logic clear_regs, reset_filter, usage_stride_pos_ld, psum_clear;
  logic psum_ren, psum_same_addr, accumulate, done;

  pe_row_tracker #(
    .ROW_W (ROW_W)
  ) u_row_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (row_clear),
    .inc      (row_inc),
    .rows     (rows_q),
    .row_idx  (row_idx),
    .last_row (last_row)
  );

  assign busy = state_is_busy(state_q);

  // Job configuration is captured only on start and held for the whole job.
  always_comb begin
    mode_d     = mode_q;
    rows_d     = rows_q;
    just_add_d = just_add_q;
    if (bus.start) begin
      mode_d     = bus.mode;
      rows_d     = bus.row_count;
      just_add_d = bus.just_add;
    end
  end

  // Next state and outputs. Moore defaults first; the Mealy terms are the
  // clear_regs, reset_filter and accumulate assignments.
  always_comb begin
    state_d             = state_q;
    row_clear           = bus.start;
    row_inc             = 1'b0;
    reset_all           = 1'b0;
    if_read_start       = 1'b0;
    filter_read_start   = 1'b0;
    start_rd_gen        = 1'b0;
    clear_regs          = 1'b0;
    reset_filter        = 1'b0;
    usage_stride_pos_ld = 1'b1;
    psum_clear          = 1'b0;
    psum_ren            = 1'b0;
    psum_same_addr      = 1'b1;
    accumulate          = 1'b0;
    done                = 1'b0;

    case (state_q)
      S_IDLE: begin
        reset_all = 1'b1;
      end
      S_LOAD: begin
        if_read_start     = 1'b1;
        filter_read_start = 1'b1;
        state_d           = S_DISPATCH;
      end
      S_DISPATCH: begin
        start_rd_gen = 1'b1;
        if (just_add_q) begin
          state_d = S_DRAIN;
        end else if (mode_q == MODE_W'(MODE_STREAM)) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_PRIME;
        end
      end
      S_STREAM: begin
        clear_regs = bus.psum_done | bus.stride_count_flag;
        if (bus.full_done) begin
          state_d = S_DONE;
        end
      end
      S_PRIME: begin
        // The first stride position only primes the pipeline; rows start after it.
        if (bus.stride_pos_ld) begin
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        clear_regs          = bus.psum_done | bus.stride_count_flag;
        usage_stride_pos_ld = 1'b0;
        if (bus.stride_pos_ld) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            reset_filter = 1'b1;
            row_inc      = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        psum_ren       = 1'b1;
        psum_same_addr = 1'b0;
        accumulate     = ~bus.psum_buf_empty & bus.psum_empty;
        if (bus.psum_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        psum_clear = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new request overrides whatever the job was doing, including a
    // completion in the same cycle, so no done pulse is produced for it.
    if (bus.start) begin
      state_d = S_LOAD;
    end
  end

`ifdef PE_JOB_PERF_EN
  logic [15:0] job_cycles_q, job_cycles_d;

  always_comb begin
    job_cycles_d = job_cycles_q;
    if (bus.start) begin
      job_cycles_d = '0;
    end else if (busy && (job_cycles_q != 16'hFFFF)) begin
      job_cycles_d = job_cycles_q + 16'd1;
    end
  end

  assign job_cycles = job_cycles_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      rows_q     <= '0;
      just_add_q <= 1'b0;
`ifdef PE_JOB_PERF_EN
      job_cycles_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rows_q     <= rows_d;
      just_add_q <= just_add_d;
`ifdef PE_JOB_PERF_EN
      job_cycles_q <= job_cycles_d;
`endif
    end
  end

  assign bus.busy                = busy;
  assign bus.done                = done;
  assign bus.row_idx             = row_idx;
  assign bus.reset_all           = reset_all;
  assign bus.if_read_start       = if_read_start;
  assign bus.filter_read_start   = filter_read_start;
  assign bus.start_rd_gen        = start_rd_gen;
  assign bus.clear_regs          = clear_regs;
  assign bus.reset_filter        = reset_filter;
  assign bus.usage_stride_pos_ld = usage_stride_pos_ld;
  assign bus.psum_clear          = psum_clear;
  assign bus.psum_ren            = psum_ren;
  assign bus.psum_same_addr      = psum_same_addr;
  assign bus.accumulate          = accumulate;

endmodule

// File: tb/tb_pe_job_controller.sv
// -----------------------------------------------------------------------------
// tb_pe_job_controller
//   Directed bench for pe_job_controller: reset state, streaming job, row jobs
//   (3, 0 and 7 rows), psum drain job, abort/restart mid-row and start
//   colliding with a completion event. Optional PE_JOB_PERF_EN checks too.
// -----------------------------------------------------------------------------
module tb_pe_job_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks_total = 0;
  int errors       = 0;

  pe_job_controller_if #(.MODE_W(2), .ROW_W(3)) bus ();

`ifdef PE_JOB_PERF_EN
  logic [15:0] job_cycles;
`endif

  pe_job_controller #(
    .MODE_W (2),
    .ROW_W  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PE_JOB_PERF_EN
    ,
    .job_cycles (job_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_status();
    bus.full_done         = 1'b0;
    bus.stride_pos_ld     = 1'b0;
    bus.psum_done         = 1'b0;
    bus.stride_count_flag = 1'b0;
    bus.psum_buf_empty    = 1'b1;
    bus.psum_empty        = 1'b0;
  endtask

  // Issue a one-cycle start; returns with the DUT in LOAD, then walks
  // through LOAD and DISPATCH checking the kick-off strobes.
  task automatic launch(input logic [1:0] mode, input logic [2:0] rows, input logic just_add);
    bus.mode      = mode;
    bus.row_count = rows;
    bus.just_add  = just_add;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    #1;
    check_eq("load_if_read_start", bus.if_read_start, 1);
    check_eq("load_filter_read_start", bus.filter_read_start, 1);
    check_eq("load_busy", bus.busy, 1);
    check_eq("load_row_idx", bus.row_idx, 0);
    tick();
    check_eq("dispatch_start_rd_gen", bus.start_rd_gen, 1);
    tick();
  endtask

  task automatic row_job(input logic [2:0] rows_in, input int eff_rows);
    launch(2'd1, rows_in, 1'b0);
    check_eq("prime_usage", bus.usage_stride_pos_ld, 1);
    bus.stride_pos_ld = 1'b1;
    #1;
    check_eq("prime_reset_filter", bus.reset_filter, 0);
    tick();
    bus.stride_pos_ld = 1'b0;
    #1;
    for (int i = 0; i < eff_rows; i++) begin
      check_eq("row_idx", bus.row_idx, i);
      check_eq("row_usage", bus.usage_stride_pos_ld, 0);
      bus.stride_pos_ld = 1'b1;
      #1;
      check_eq("row_reset_filter", bus.reset_filter, (i != eff_rows - 1) ? 1 : 0);
      check_eq("row_done_early", bus.done, 0);
      tick();
      bus.stride_pos_ld = 1'b0;
      #1;
    end
    check_eq("row_done", bus.done, 1);
    check_eq("row_final_idx", bus.row_idx, eff_rows - 1);
    check_eq("row_done_busy", bus.busy, 0);
    check_eq("row_psum_clear", bus.psum_clear, 1);
    tick();
    check_eq("row_idle_done", bus.done, 0);
    check_eq("row_idle_reset_all", bus.reset_all, 1);
    $display("row job rows=%0d: final row_idx=%0d", rows_in, bus.row_idx);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.mode      = '0;
    bus.row_count = '0;
    bus.just_add  = 1'b0;
    clear_status();

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_reset_all", bus.reset_all, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_row_idx", bus.row_idx, 0);
    check_eq("rst_psum_same_addr", bus.psum_same_addr, 1);
    check_eq("rst_usage", bus.usage_stride_pos_ld, 1);
    check_eq("rst_if_read_start", bus.if_read_start, 0);
`ifdef PE_JOB_PERF_EN
    check_eq("rst_job_cycles", job_cycles, 0);
`endif
    rst = 1'b0;
    tick();
    $display("reset: reset_all=%0b busy=%0b", bus.reset_all, bus.busy);

    // Streaming job
    launch(2'd0, 3'd0, 1'b0);
    check_eq("stream_busy", bus.busy, 1);
    check_eq("stream_clear_idle", bus.clear_regs, 0);
    bus.psum_done = 1'b1;
    #1;
    check_eq("stream_clear_psum", bus.clear_regs, 1);
    bus.psum_done = 1'b0;
    bus.stride_count_flag = 1'b1;
    #1;
    check_eq("stream_clear_stride", bus.clear_regs, 1);
    bus.stride_count_flag = 1'b0;
    #1;
    check_eq("stream_clear_off", bus.clear_regs, 0);
    tick();
    tick();
    check_eq("stream_wait_done", bus.done, 0);
    bus.full_done = 1'b1;
    #1;
    check_eq("stream_done_same", bus.done, 0);
    tick();
    bus.full_done = 1'b0;
    #1;
    check_eq("stream_done", bus.done, 1);
    check_eq("stream_done_busy", bus.busy, 0);
    check_eq("stream_psum_clear", bus.psum_clear, 1);
    tick();
    check_eq("stream_idle", bus.reset_all, 1);
    check_eq("stream_idle_done", bus.done, 0);
    $display("stream job: done seen one cycle after full_done");

    // Row jobs: 3 rows, 0 (acts as 1), 7 (peaks at 6)
    row_job(3'd3, 3);
    row_job(3'd0, 1);
    row_job(3'd7, 7);

    // Psum drain job
    launch(2'd2, 3'd0, 1'b1);
    check_eq("drain_ren", bus.psum_ren, 1);
    check_eq("drain_same_addr", bus.psum_same_addr, 0);
    check_eq("drain_acc_both_empty", bus.accumulate, 0);
    bus.psum_buf_empty = 1'b0;
    #1;
    check_eq("drain_acc_scratch_busy", bus.accumulate, 0);
    tick();
    bus.psum_empty = 1'b1;
    #1;
    check_eq("drain_acc", bus.accumulate, 1);
    check_eq("drain_done_same", bus.done, 0);
    tick();
    clear_status();
    #1;
    check_eq("drain_done", bus.done, 1);
    check_eq("drain_ren_off", bus.psum_ren, 0);
    tick();
    $display("drain job: accumulate and done observed");

    // Abort mid-row with row_idx=2, restart as a streaming job
    bus.mode = 2'd1; bus.row_count = 3'd5; bus.just_add = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.stride_pos_ld = 1'b1;
    tick();
    tick();
    tick();
    bus.stride_pos_ld = 1'b0;
    #1;
    check_eq("abort_row_idx_before", bus.row_idx, 2);
    check_eq("abort_busy_before", bus.busy, 1);
    bus.mode = 2'd0; bus.row_count = 3'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check_eq("abort_load", bus.if_read_start, 1);
    check_eq("abort_row_idx", bus.row_idx, 0);
    check_eq("abort_no_done", bus.done, 0);
`ifdef PE_JOB_PERF_EN
    check_eq("abort_job_cycles_clr", job_cycles, 0);
`endif
    tick();
    check_eq("abort_dispatch", bus.start_rd_gen, 1);
`ifdef PE_JOB_PERF_EN
    check_eq("abort_job_cycles_1", job_cycles, 1);
`endif
    tick();
    $display("abort: restarted into stream pass, row_idx=%0d", bus.row_idx);

    // Start colliding with full_done: start wins, no done pulse
    bus.full_done = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.full_done = 1'b0;
    bus.start = 1'b0;
    #1;
    check_eq("collide_no_done", bus.done, 0);
    check_eq("collide_load", bus.if_read_start, 1);
    tick();
    tick();
    bus.full_done = 1'b1;
    tick();
    bus.full_done = 1'b0;
    #1;
    check_eq("collide_final_done", bus.done, 1);
    tick();
    $display("collision: start took priority over full_done");

    $display("Result: errors=%0d of %0d checks", errors, checks_total);
    $finish;
  end

endmodule
